// File: rtl/blink_gen.sv
// blink_gen: shared tick prescaler driving N_CH independent off/on/blink/one-shot output channels.
// Latency: a load takes effect at its own edge; oAck and oDone are registered, one cycle after their cause.
// Backpressure: none; every in-range load is accepted at once, out-of-range loads are dropped.
//
// Ports:
//   iClk      - single clock, rising edge
//   iRst      - synchronous active-high reset
//   iLoad     - one-cycle strobe writing {iMode, iHalfPer} into channel iCh
//   iCh       - target channel index for iLoad
//   iMode     - 00 off, 01 on, 10 blink, 11 one-shot
//   iHalfPer  - half-period in prescaler ticks (0 behaves as 1)
//   oAck      - one-cycle acknowledge of an accepted load
//   oTick     - prescaler tick, one cycle every DIV cycles
//   oOut      - per-channel output levels
//   oDone     - per-channel one-shot completion pulse
module blink_gen #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 10,
  parameter int N_CH     = 4,
  parameter int PER_W    = 8,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iLoad,
  input  logic [CH_W-1:0]  iCh,
  input  logic [1:0]       iMode,
  input  logic [PER_W-1:0] iHalfPer,
  output logic             oAck,
  output logic             oTick,
  output logic [N_CH-1:0]  oOut,
  output logic [N_CH-1:0]  oDone
);

  // DIV is expected to be at least 2 so the counter has a real wrap point.
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  // Tick is decoded purely from the counter register, so it has no input path.
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Load decode
  // ---------------------------------------------------------------------------
  logic            load_ok;
  logic [N_CH-1:0] load_sel;
  logic            ack_d, ack_q;

  // iCh may be wider than needed when N_CH is not a power of two.
  assign load_ok = iLoad && (int'(iCh) < N_CH);
  assign ack_d   = load_ok;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      load_sel[c] = load_ok && (int'(iCh) == c);
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  mode_e            mode_q [N_CH];
  mode_e            mode_d [N_CH];
  logic [PER_W-1:0] hp_q   [N_CH];
  logic [PER_W-1:0] hp_d   [N_CH];
  logic [PER_W-1:0] cnt_q  [N_CH];
  logic [PER_W-1:0] cnt_d  [N_CH];
  logic [PER_W-1:0] h_last [N_CH];
  logic [N_CH-1:0]  wrap;
  logic [N_CH-1:0]  out_q, out_d;
  logic [N_CH-1:0]  done_q, done_d;

  // Terminal count is H-1 with H = max(half-period, 1); a zero half-period
  // therefore wraps on every tick.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      h_last[c] = (hp_q[c] == '0) ? '0 : hp_q[c] - 1'b1;
      wrap[c]   = (cnt_q[c] == h_last[c]);
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      mode_d[c] = mode_q[c];
      hp_d[c]   = hp_q[c];
      cnt_d[c]  = cnt_q[c];
      out_d[c]  = out_q[c];
      done_d[c] = 1'b0;

      if (load_sel[c]) begin
        // A load always wins over a coincident tick on the same channel.
        mode_d[c] = mode_e'(iMode);
        hp_d[c]   = iHalfPer;
        cnt_d[c]  = '0;
        out_d[c]  = (iMode != MODE_OFF);
      end else begin
        case (mode_q[c])
          MODE_OFF: begin
            out_d[c] = 1'b0;
          end
          MODE_ON: begin
            out_d[c] = 1'b1;
          end
          MODE_BLINK: begin
            if (tick) begin
              if (wrap[c]) begin
                cnt_d[c] = '0;
                out_d[c] = ~out_q[c];
              end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
              end
            end
          end
          MODE_ONESHOT: begin
            if (tick) begin
              if (wrap[c]) begin
                cnt_d[c]  = '0;
                out_d[c]  = 1'b0;
                mode_d[c] = MODE_OFF;
                done_d[c] = 1'b1;
              end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
              end
            end
          end
          default: begin
            out_d[c] = out_q[c];
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      presc_q <= '0;
      ack_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        mode_q[c] <= MODE_OFF;
        hp_q[c]   <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      presc_q <= presc_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
      done_q  <= done_d;
      for (int c = 0; c < N_CH; c++) begin
        mode_q[c] <= mode_d[c];
        hp_q[c]   <= hp_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  assign oTick = tick;
  assign oAck  = ack_q;
  assign oOut  = out_q;
  assign oDone = done_q;

endmodule
